// File: rtl/estado_tamagotchi.sv
// Plant-state producer for the main controller: debounced need classification with sticky death,
// plus a button-driven test sequence. Optional blink output guarded by ESTADO_ALERTA_EN.
module estado_tamagotchi #(
    parameter int unsigned TEST_HOLD_CYCLES  = 250000000,
    parameter int unsigned RESET_HOLD_CYCLES = 250000000,
    parameter int unsigned MIN_STABLE        = 4,
    parameter int unsigned DEATH_SECONDS     = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       passsecond,
    input  logic       botontest,
    input  logic       botonreset,
    input  logic [2:0] humedad,
    input  logic [2:0] nutricion,
    input  logic [2:0] energia,
    input  logic [2:0] mantenimiento,
    input  logic [2:0] cortado,
    input  logic       reposando,
    output logic [3:0] estado,
    output logic       estado_cambio,
    output logic       modo_test,
    output logic       alerta
);

    typedef enum logic [3:0] {
        FELIZ      = 4'b0000,
        CANSADO    = 4'b0001,
        DURMIENDO  = 4'b0010,
        HAMBRIENTO = 4'b0011,
        SEDIENTO   = 4'b0100,
        ABURRIDO   = 4'b0101,
        DESALINADO = 4'b0110,
        ENFERMO    = 4'b0111,
        MURIENDO   = 4'b1000,
        MUERTO     = 4'b1001,
        NORMAL     = 4'b1010
    } estado_t;

    localparam int unsigned TW = $clog2(TEST_HOLD_CYCLES + 1);
    localparam int unsigned RW = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int unsigned SW = $clog2(MIN_STABLE + 1);
    localparam int unsigned DW = $clog2(DEATH_SECONDS + 1);

    localparam logic [TW-1:0] TMAX    = TW'(TEST_HOLD_CYCLES);
    localparam logic [TW-1:0] TMAX_M1 = TW'(TEST_HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RMAX    = RW'(RESET_HOLD_CYCLES);
    localparam logic [RW-1:0] RMAX_M1 = RW'(RESET_HOLD_CYCLES - 1);
    localparam logic [SW-1:0] SMAX_M1 = SW'(MIN_STABLE - 1);
    localparam logic [DW-1:0] DMAX_M1 = DW'(DEATH_SECONDS - 1);

    estado_t       est_q, est_d, pend_q, pend_d, cand;
    logic          cambio_q, modo_q, modo_d, muerto_q, muerto_d;
    logic          ps_q, bt_q;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [2:0]    n_crit;
    logic [1:0]    n_sick;
    logic          ps_edge, bt_fall, rst_fire, test_fire, long_release;

    assign ps_edge      = passsecond & ~ps_q;
    assign bt_fall      = bt_q & ~botontest;
    assign rst_fire     = botonreset && (rcnt_q == RMAX_M1);
    assign test_fire    = botontest && (tcnt_q == TMAX_M1);
    assign long_release = bt_fall && (tcnt_q == TMAX);

    always_comb begin
        n_crit = {2'b00, humedad <= 3'd1} + {2'b00, nutricion <= 3'd1}
               + {2'b00, energia <= 3'd1} + {2'b00, mantenimiento <= 3'd1};
        n_sick = {1'b0, humedad <= 3'd2} + {1'b0, nutricion <= 3'd2} + {1'b0, energia <= 3'd2};
        cand = NORMAL;
        if (muerto_q)                 cand = MUERTO;
        else if (n_crit >= 3'd3)      cand = MURIENDO;
        else if (n_sick >= 2'd2)      cand = ENFERMO;
        else if (reposando)           cand = DURMIENDO;
        else if (humedad <= 3'd4)     cand = SEDIENTO;
        else if (nutricion <= 3'd4)   cand = HAMBRIENTO;
        else if (energia <= 3'd4)     cand = CANSADO;
        else if (mantenimiento <= 3'd4) cand = ABURRIDO;
        else if (cortado <= 3'd4)     cand = DESALINADO;
        else if (humedad == 3'd7 && nutricion == 3'd7 && energia == 3'd7 &&
                 mantenimiento == 3'd7 && cortado == 3'd7)
                                      cand = FELIZ;
    end

    always_comb begin
        est_d    = est_q;
        pend_d   = pend_q;
        modo_d   = modo_q;
        muerto_d = muerto_q;
        scnt_d   = scnt_q;
        dcnt_d   = dcnt_q;
        tcnt_d   = '0;
        rcnt_d   = '0;

        // Hold counters saturate, so each hold fires once and needs a release to re-arm.
        if (botontest)  tcnt_d = (tcnt_q == TMAX) ? tcnt_q : tcnt_q + TW'(1);
        if (botonreset) rcnt_d = (rcnt_q == RMAX) ? rcnt_q : rcnt_q + RW'(1);

        if (rst_fire) begin
            modo_d   = 1'b0;
            muerto_d = 1'b0;
            est_d    = NORMAL;
            pend_d   = NORMAL;
            tcnt_d   = '0;
            scnt_d   = '0;
            dcnt_d   = '0;
        end else if (test_fire) begin
            modo_d = 1'b1;
            est_d  = FELIZ;
            scnt_d = '0;
        end else if (modo_q) begin
            scnt_d = '0;
            if (bt_fall && !long_release) begin
                if (est_q == MURIENDO)                         est_d = NORMAL;
                else if (est_q == NORMAL || est_q == MUERTO)   est_d = FELIZ;
                else                                           est_d = estado_t'(est_q + 4'd1);
            end
        end else begin
            if (cand == MURIENDO) begin
                if (ps_edge) begin
                    dcnt_d = dcnt_q + DW'(1);
                    if (dcnt_q == DMAX_M1) muerto_d = 1'b1;
                end
            end else begin
                dcnt_d = '0;
            end

            if (cand == est_q) begin
                scnt_d = '0;
            end else if (muerto_q) begin
                est_d  = MUERTO;
                scnt_d = '0;
            end else if (scnt_q == '0 || cand != pend_q) begin
                pend_d = cand;
                if (MIN_STABLE <= 1) begin
                    est_d  = cand;
                    scnt_d = '0;
                end else begin
                    scnt_d = SW'(1);
                end
            end else if (scnt_q == SMAX_M1) begin
                est_d  = cand;
                scnt_d = '0;
            end else begin
                scnt_d = scnt_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            est_q    <= NORMAL;
            pend_q   <= NORMAL;
            cambio_q <= 1'b0;
            modo_q   <= 1'b0;
            muerto_q <= 1'b0;
            ps_q     <= 1'b0;
            bt_q     <= 1'b0;
            tcnt_q   <= '0;
            rcnt_q   <= '0;
            scnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            est_q    <= est_d;
            pend_q   <= pend_d;
            cambio_q <= (est_d != est_q);
            modo_q   <= modo_d;
            muerto_q <= muerto_d;
            ps_q     <= passsecond;
            bt_q     <= botontest;
            tcnt_q   <= tcnt_d;
            rcnt_q   <= rcnt_d;
            scnt_q   <= scnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign estado        = est_q;
    assign estado_cambio = cambio_q;
    assign modo_test     = modo_q;

`ifdef ESTADO_ALERTA_EN
    logic alerta_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            alerta_q <= 1'b0;
        else if (modo_q || !(est_q inside {ENFERMO, MURIENDO, MUERTO}))
            alerta_q <= 1'b0;
        else if (ps_edge)
            alerta_q <= ~alerta_q;
    end

    assign alerta = alerta_q;
`else
    assign alerta = 1'b0;
`endif

endmodule

// File: tb/tb_estado_tamagotchi.sv
// Directed bench for estado_tamagotchi: classification table plus debounce, death, alert,
// test-mode and async-reset sequences.
module tb_estado_tamagotchi;

    logic       clk = 1'b0;
    logic       reset, passsecond, botontest, botonreset, reposando;
    logic [2:0] humedad, nutricion, energia, mantenimiento, cortado;
    logic [3:0] estado;
    logic       estado_cambio, modo_test, alerta;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct {
        logic [2:0]  h, n, e, m, c;
        logic        rep;
        int unsigned cyc;
        logic [3:0]  exp;
    } vec_t;

    vec_t vt[15];

    estado_tamagotchi #(
        .TEST_HOLD_CYCLES (10),
        .RESET_HOLD_CYCLES(10),
        .MIN_STABLE       (4),
        .DEATH_SECONDS    (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .passsecond   (passsecond),
        .botontest    (botontest),
        .botonreset   (botonreset),
        .humedad      (humedad),
        .nutricion    (nutricion),
        .energia      (energia),
        .mantenimiento(mantenimiento),
        .cortado      (cortado),
        .reposando    (reposando),
        .estado       (estado),
        .estado_cambio(estado_cambio),
        .modo_test    (modo_test),
        .alerta       (alerta)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic levels(input logic [2:0] h, n, e, m, c, input logic rep);
        humedad = h; nutricion = n; energia = e; mantenimiento = m; cortado = c; reposando = rep;
    endtask

    task automatic pulse_second();
        passsecond = 1'b1;
        tick();
        tick();
        passsecond = 1'b0;
        tick();
        tick();
    endtask

    task automatic press_release();
        botontest = 1'b1;
        tick();
        tick();
        botontest = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  prev;
        int unsigned pulses;
        logic [3:0]  seq[10];
        logic        alert_exp[4];

        vt[0]  = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 1'b0, 20, 4'b1010};
        vt[1]  = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 1'b0, 6,  4'b0000};
        vt[2]  = '{3'd4, 3'd7, 3'd7, 3'd7, 3'd7, 1'b0, 6,  4'b0100};
        vt[3]  = '{3'd7, 3'd4, 3'd7, 3'd7, 3'd7, 1'b0, 6,  4'b0011};
        vt[4]  = '{3'd7, 3'd7, 3'd4, 3'd7, 3'd7, 1'b0, 6,  4'b0001};
        vt[5]  = '{3'd7, 3'd7, 3'd7, 3'd4, 3'd7, 1'b0, 6,  4'b0101};
        vt[6]  = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd4, 1'b0, 6,  4'b0110};
        vt[7]  = '{3'd4, 3'd4, 3'd7, 3'd7, 3'd7, 1'b1, 6,  4'b0010};
        vt[8]  = '{3'd2, 3'd2, 3'd6, 3'd6, 3'd6, 1'b1, 6,  4'b0111};
        vt[9]  = '{3'd1, 3'd1, 3'd6, 3'd1, 3'd6, 1'b0, 6,  4'b1000};
        vt[10] = '{3'd1, 3'd7, 3'd1, 3'd7, 3'd7, 1'b0, 6,  4'b0111};
        vt[11] = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 1'b0, 6,  4'b1010};
        vt[12] = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 1'b0, 6,  4'b1010};
        vt[13] = '{3'd2, 3'd5, 3'd5, 3'd2, 3'd7, 1'b0, 6,  4'b0100};
        vt[14] = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 1'b0, 6,  4'b1010};

        seq = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b0000};
`ifdef ESTADO_ALERTA_EN
        alert_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        alert_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        reset = 1'b1; passsecond = 1'b0; botontest = 1'b0; botonreset = 1'b0;
        levels(3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 1'b0);
        #12;
        chk("reset_estado", estado, 4'b1010);
        chk("reset_cambio", estado_cambio, 0);
        chk("reset_modo",   modo_test, 0);
        chk("reset_alerta", alerta, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        prev = 4'b1010;
        for (int i = 0; i < 15; i++) begin
            levels(vt[i].h, vt[i].n, vt[i].e, vt[i].m, vt[i].c, vt[i].rep);
            pulses = 0;
            for (int k = 0; k < int'(vt[i].cyc); k++) begin
                tick();
                if (estado_cambio) pulses++;
            end
            chk($sformatf("vec%0d_estado", i), estado, vt[i].exp);
            chk($sformatf("vec%0d_pulses", i), pulses, (vt[i].exp != prev) ? 1 : 0);
            chk($sformatf("vec%0d_alerta", i), alerta, 0);
            prev = vt[i].exp;
        end

        // Debounce: a 3-cycle dip is ignored, a sustained one commits on the 4th edge.
        levels(3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 1'b0);
        tick();
        humedad = 3'd4;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin tick(); if (estado_cambio) pulses++; end
        humedad = 3'd6;
        for (int k = 0; k < 6; k++) begin tick(); if (estado_cambio) pulses++; end
        chk("glitch_estado", estado, 4'b1010);
        chk("glitch_pulses", pulses, 0);
        humedad = 3'd4;
        for (int k = 0; k < 3; k++) tick();
        chk("deb_3cyc_estado", estado, 4'b1010);
        tick();
        chk("deb_4cyc_estado", estado, 4'b0100);
        chk("deb_4cyc_cambio", estado_cambio, 1);
        tick();
        chk("deb_5cyc_cambio", estado_cambio, 0);

        // Death: three passsecond edges in MURIENDO latch MUERTO, cleared only by a reset hold.
        levels(3'd1, 3'd1, 3'd1, 3'd1, 3'd6, 1'b0);
        for (int k = 0; k < 6; k++) tick();
        chk("dying_estado", estado, 4'b1000);
        pulse_second();
        pulse_second();
        chk("dying_2s_estado", estado, 4'b1000);
        pulse_second();
        chk("dead_estado", estado, 4'b1001);
        levels(3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        chk("dead_sticky", estado, 4'b1001);
        botonreset = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        chk("rhold_9_estado", estado, 4'b1001);
        tick();
        chk("rhold_10_estado", estado, 4'b1010);
        chk("rhold_10_cambio", estado_cambio, 1);
        botonreset = 1'b0;

        // Alert blink while ENFERMO.
        levels(3'd2, 3'd2, 3'd7, 3'd7, 3'd7, 1'b0);
        for (int k = 0; k < 6; k++) tick();
        chk("sick_estado", estado, 4'b0111);
        chk("sick_alerta0", alerta, 0);
        for (int p = 0; p < 4; p++) begin
            pulse_second();
            chk($sformatf("alerta_%0d", p), alerta, alert_exp[p]);
        end

        // Test mode entry and stepping.
        botontest = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        chk("thold_9_modo", modo_test, 0);
        tick();
        chk("thold_10_modo", modo_test, 1);
        chk("thold_10_estado", estado, 4'b0000);
        botontest = 1'b0;
        tick();
        tick();
        chk("entry_release_estado", estado, 4'b0000);
        for (int s = 0; s < 10; s++) begin
            press_release();
            chk($sformatf("step%0d_estado", s), estado, seq[s]);
            chk($sformatf("step%0d_cambio", s), estado_cambio, 1);
            chk($sformatf("step%0d_alerta", s), alerta, 0);
        end

        // Async reset in the middle of stepping.
        press_release();
        press_release();
        chk("prereset_estado", estado, 4'b0010);
        levels(3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_estado", estado, 4'b1010);
        chk("areset_modo",   modo_test, 0);
        chk("areset_cambio", estado_cambio, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_cambio", estado_cambio, 0);
        chk("post_reset_estado", estado, 4'b1010);
        chk("post_reset_modo",   modo_test, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
